// File: rtl/ram_ws.sv
// Parametrised single-port block RAM with wait states, byte write enables and a READY pulse.
// Optional power-up clear sweep is compiled in with `define RAM_WS_CLEAR_EN.
module ram_ws #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                nCS,
  input  logic                nWE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   ADDR,
  input  logic [DATA_W-1:0]   DI,
  output logic [DATA_W-1:0]   DO,
  output logic                READY,
  output logic                BUSY
);

  localparam int NB   = DATA_W / 8;
  localparam int AW_I = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef RAM_WS_CLEAR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
`endif

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   di_q;
  logic [DATA_W-1:0]   do_q;
  logic                ready_q;
  logic                busy_q;
`ifdef RAM_WS_CLEAR_EN
  logic                clr_pend_q;
  logic [ADDR_W-1:0]   sweep_q;
`endif

  logic                in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_idx;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_be;
  logic [DATA_W-1:0]   rd_word;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  // One write port shared by bus writes and the clear sweep; reset suppresses any write.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = addr_q;
    mem_wdata = di_q;
    mem_be    = be_q;
    if (!RST && state_q == S_ACCESS && we_q && in_range) begin
      mem_we = 1'b1;
    end
`ifdef RAM_WS_CLEAR_EN
    if (!RST && state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = sweep_q;
      mem_wdata = '0;
      mem_be    = '1;
    end
`endif
  end

  // Byte-wide banks so each byte lane maps onto its own RAM write enable.
  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    logic [7:0] bank [DEPTH];
    always_ff @(posedge CLK) begin
      if (mem_we && mem_be[gi]) begin
        bank[mem_idx[AW_I-1:0]] <= mem_wdata[gi*8 +: 8];
      end
    end
    assign rd_word[gi*8 +: 8] = bank[addr_q[AW_I-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      do_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RAM_WS_CLEAR_EN
      clr_pend_q <= 1'b1;
      sweep_q    <= '0;
`endif
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef RAM_WS_CLEAR_EN
          if (clr_pend_q) begin
            clr_pend_q <= 1'b0;
            sweep_q    <= '0;
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
          end else
`endif
          if (!nCS) begin
            addr_q <= ADDR;
            we_q   <= !nWE;
            be_q   <= BE;
            di_q   <= DI;
            busy_q <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          if (!we_q) do_q <= in_range ? rd_word : '0;
          ready_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
`ifdef RAM_WS_CLEAR_EN
        S_CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if ({1'b0, sweep_q} == DEPTH_L - 1'b1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign DO    = do_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;

endmodule
